// File: rtl/mux8_ser_pkg.sv
// Shared types and constants for the 8-bit parallel-to-serial front end.
package mux8_ser_pkg;

    localparam int SEL_W  = 3;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        PARITY = 2'd2,
        GAP    = 2'd3
    } state_e;

    // Select index of the first and final data bit for a given bit order.
    function automatic logic [SEL_W-1:0] first_idx(input int msb_first);
        return (msb_first != 0) ? 3'd7 : 3'd0;
    endfunction

    function automatic logic [SEL_W-1:0] last_idx(input int msb_first);
        return (msb_first != 0) ? 3'd0 : 3'd7;
    endfunction

endpackage

// File: rtl/mux8_serializer_if.sv
// Handshake bundle between upstream word source, serializer and serial sink.
interface mux8_serializer_if;
    import mux8_ser_pkg::*;

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              ser_bit;
    logic              ser_valid;
    logic              ser_ready;
    logic              ser_last;
    logic [SEL_W-1:0]  sel;
    logic              busy;

    modport slave (
        input  in_data, in_valid, ser_ready,
        output in_ready, ser_bit, ser_valid, ser_last, sel, busy
    );

    modport master (
        output in_data, in_valid, ser_ready,
        input  in_ready, ser_bit, ser_valid, ser_last, sel, busy
    );

endinterface

// File: rtl/mux8_serializer_mux8to1.sv
// Plain 8:1 bit-select mux used as the serializer's bit picker.
module mux8to1
    import mux8_ser_pkg::*;
(
    input  logic [DATA_W-1:0] d,
    input  logic [SEL_W-1:0]  s,
    output logic              o
);

    assign o = d[s];

endmodule

// File: rtl/mux8_serializer.sv
// Parallel-to-serial stage: holds one word and walks the 8:1 select across it.
// Define MUX8_SERIALIZER_PARITY_EN to append an even-parity beat after each word.
module mux8_serializer
    import mux8_ser_pkg::*;
#(
    parameter int MSB_FIRST  = 0,
    parameter int GAP_CYCLES = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    mux8_serializer_if.slave   bus
);

    localparam logic [SEL_W-1:0] FIRST_IDX = first_idx(MSB_FIRST);
    localparam logic [SEL_W-1:0] LAST_IDX  = last_idx(MSB_FIRST);
    localparam logic [3:0]       GAP_LAST  = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
    localparam logic [1:0]       AFTER_WORD = (GAP_CYCLES > 0) ? GAP : IDLE;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [3:0]        gap_q, gap_d;
    logic              mux_o;
    logic              valid_w;
    logic              beat_w;

    mux8to1 u_mux (
        .d (hold_q),
        .s (sel_q),
        .o (mux_o)
    );

`ifdef MUX8_SERIALIZER_PARITY_EN
    assign valid_w = (state_q == SEND) || (state_q == PARITY);
`else
    assign valid_w = (state_q == SEND);
`endif
    assign beat_w = valid_w && bus.ser_ready;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        sel_d   = sel_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    hold_d  = bus.in_data;
                    sel_d   = FIRST_IDX;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (beat_w) begin
                    if (sel_q == LAST_IDX) begin
                        gap_d = 4'd0;
`ifdef MUX8_SERIALIZER_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = AFTER_WORD;
`endif
                    end else begin
                        sel_d = (MSB_FIRST != 0) ? sel_q - 3'd1 : sel_q + 3'd1;
                    end
                end
            end
`ifdef MUX8_SERIALIZER_PARITY_EN
            PARITY: begin
                if (beat_w) begin
                    gap_d   = 4'd0;
                    state_d = AFTER_WORD;
                end
            end
`endif
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = 4'd0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A reset mid-word simply drops the word; nothing is flushed out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            sel_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            sel_q   <= sel_d;
            gap_q   <= gap_d;
        end
    end

    assign bus.in_ready  = rst_n && (state_q == IDLE);
    assign bus.ser_valid = valid_w;
    assign bus.sel       = sel_q;
    assign bus.busy      = (state_q != IDLE);

`ifdef MUX8_SERIALIZER_PARITY_EN
    assign bus.ser_bit  = (state_q == SEND) ? mux_o : ((state_q == PARITY) ? ^hold_q : 1'b0);
    assign bus.ser_last = (state_q == PARITY);
`else
    assign bus.ser_bit  = (state_q == SEND) ? mux_o : 1'b0;
    assign bus.ser_last = (state_q == SEND) && (sel_q == LAST_IDX);
`endif

endmodule

// File: tb/tb_mux8_serializer.sv
// Bench for mux8_serializer: three instances (LSB-first, MSB-first, 3-cycle gap).
module tb_mux8_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] in_data   [3];
    logic       in_valid  [3];
    logic       ser_ready [3];

    logic [2:0] in_ready_w, ser_bit_w, ser_valid_w, ser_last_w, busy_w;
    logic [8:0] sel_flat;

    int tests = 0;
    int fails = 0;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        mux8_serializer_if bus ();
        assign bus.in_data      = in_data[gi];
        assign bus.in_valid     = in_valid[gi];
        assign bus.ser_ready    = ser_ready[gi];
        assign in_ready_w[gi]   = bus.in_ready;
        assign ser_bit_w[gi]    = bus.ser_bit;
        assign ser_valid_w[gi]  = bus.ser_valid;
        assign ser_last_w[gi]   = bus.ser_last;
        assign busy_w[gi]       = bus.busy;
        assign sel_flat[gi*3 +: 3] = bus.sel;

        mux8_serializer #(
            .MSB_FIRST  ((gi == 1) ? 1 : 0),
            .GAP_CYCLES ((gi == 2) ? 3 : 0)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    // Reference model: bit order and framing straight from the word and its configuration.
    function automatic int cfg_msb(input int k);
        return (k == 1) ? 1 : 0;
    endfunction

    function automatic int cfg_gap(input int k);
        return (k == 2) ? 3 : 0;
    endfunction

    function automatic int n_beats();
`ifdef MUX8_SERIALIZER_PARITY_EN
        return 9;
`else
        return 8;
`endif
    endfunction

    function automatic logic exp_bit(input logic [7:0] d, input int msb, input int i);
        if (i >= 8) return ^d;
        return (msb != 0) ? d[7 - i] : d[i];
    endfunction

    function automatic logic [2:0] exp_sel(input int msb, input int i);
        return (msb != 0) ? 3'(7 - i) : 3'(i);
    endfunction

    function automatic logic [2:0] sel_of(input int k);
        return sel_flat[k*3 +: 3];
    endfunction

    // Entered and left on a falling edge.
    task automatic run_word(input int k, input logic [7:0] d, input int stall_pct,
                            input int stall_at, input int stall_len,
                            input bit hold_valid, input logic [7:0] next_d);
        int waitc = 0;
        int beat = 0;
        int stalled = 0;
        int cyc = 0;
        int nb = n_beats();
        int msb = cfg_msb(k);
        bit rdy;
        logic [3:0] obs, req;
        while (in_ready_w[k] !== 1'b1 && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        tests++;
        if (in_ready_w[k] !== 1'b1) begin
            fails++;
            $display("FAIL accept_wait k=%0d in_ready=%b required 1", k, in_ready_w[k]);
            return;
        end
        in_data[k]  = d;
        in_valid[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (hold_valid) in_data[k] = next_d;
        else in_valid[k] = 1'b0;
        while (beat < nb && cyc < 400) begin
            obs = {ser_valid_w[k], ser_bit_w[k], ser_last_w[k], in_ready_w[k]};
            req = {1'b1, exp_bit(d, msb, beat), (beat == nb - 1), 1'b0};
            tests++;
            if (obs !== req) begin
                fails++;
                $display("FAIL beat k=%0d word=%h beat=%0d {valid,bit,last,in_ready}=%b required %b",
                         k, d, beat, obs, req);
            end
            if (beat < 8) begin
                tests++;
                if (sel_of(k) !== exp_sel(msb, beat)) begin
                    fails++;
                    $display("FAIL sel k=%0d word=%h beat=%0d sel=%0d required %0d",
                             k, d, beat, sel_of(k), exp_sel(msb, beat));
                end
            end
            if (beat == stall_at && stalled < stall_len) begin
                rdy = 1'b0;
                stalled++;
            end else begin
                rdy = ($urandom_range(99) >= stall_pct);
            end
            ser_ready[k] = rdy;
            @(posedge clk);
            @(negedge clk);
            if (rdy) beat++;
            cyc++;
        end
        ser_ready[k] = 1'b1;
        tests++;
        if (beat != nb) begin
            fails++;
            $display("FAIL beat_timeout k=%0d word=%h beats=%0d required %0d", k, d, beat, nb);
        end
        for (int g = 0; g < cfg_gap(k); g++) begin
            obs = {ser_valid_w[k], ser_bit_w[k], in_ready_w[k], busy_w[k]};
            tests++;
            if (obs !== 4'b0001) begin
                fails++;
                $display("FAIL gap k=%0d cycle=%0d {valid,bit,in_ready,busy}=%b required 0001", k, g, obs);
            end
            @(negedge clk);
        end
        obs = {ser_valid_w[k], ser_last_w[k], in_ready_w[k], busy_w[k]};
        tests++;
        if (obs !== 4'b0010) begin
            fails++;
            $display("FAIL idle_after k=%0d word=%h {valid,last,in_ready,busy}=%b required 0010", k, d, obs);
        end
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            obs = {in_ready_w[k], ser_valid_w[k], ser_last_w[k], ser_bit_w[k], busy_w[k], sel_of(k)};
            tests++;
            if (obs !== 8'h00) begin
                fails++;
                $display("FAIL reset_state k=%0d {in_ready,valid,last,bit,busy,sel}=%b required 00000000", k, obs);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready_w !== 3'b111) begin
            fails++;
            $display("FAIL reset_release in_ready=%b required 111", in_ready_w);
        end
    endtask

    task automatic test_lsb_first();
        run_word(0, 8'hA5, 0, -1, 0, 1'b0, 8'h00);
    endtask

    task automatic test_msb_first();
        run_word(1, 8'h81, 0, -1, 0, 1'b0, 8'h00);
    endtask

    task automatic test_stall();
        run_word(0, 8'h3C, 0, 2, 3, 1'b0, 8'h00);
    endtask

    task automatic test_reset_midword();
        logic [3:0] obs;
        in_data[0]  = 8'hFF;
        in_valid[0] = 1'b1;
        ser_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        obs = {ser_valid_w[0], busy_w[0], ser_bit_w[0], ser_last_w[0]};
        tests++;
        if (obs !== 4'b0000 || sel_of(0) !== 3'd0) begin
            fails++;
            $display("FAIL reset_midword {valid,busy,bit,last}=%b sel=%0d required 0000 sel=0", obs, sel_of(0));
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (ser_valid_w[0] !== 1'b0 || in_ready_w[0] !== 1'b1) begin
            fails++;
            $display("FAIL reset_abort valid=%b in_ready=%b required valid=0 in_ready=1",
                     ser_valid_w[0], in_ready_w[0]);
        end
        run_word(0, 8'h0F, 0, -1, 0, 1'b0, 8'h00);
    endtask

    task automatic test_back_to_back();
        run_word(2, 8'h01, 0, -1, 0, 1'b1, 8'h02);
        run_word(2, 8'h02, 0, -1, 0, 1'b0, 8'h00);
    endtask

    task automatic test_random();
        for (int n = 0; n < 18; n++) begin
            run_word(n % 3, 8'($urandom), 35, -1, 0, 1'b0, 8'h00);
        end
    endtask

`ifdef MUX8_SERIALIZER_PARITY_EN
    task automatic test_parity();
        run_word(0, 8'h07, 0, -1, 0, 1'b0, 8'h00);
        run_word(0, 8'h03, 0, -1, 0, 1'b0, 8'h00);
        run_word(1, 8'h07, 20, -1, 0, 1'b0, 8'h00);
    endtask
`endif

    initial begin
        for (int k = 0; k < 3; k++) begin
            in_data[k]   = 8'h00;
            in_valid[k]  = 1'b0;
            ser_ready[k] = 1'b1;
        end
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_stall();
        test_reset_midword();
        test_back_to_back();
`ifdef MUX8_SERIALIZER_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux8_serializer.md
Name: mux8_serializer

Overview:
- Parallel-to-serial stage that sits directly upstream of the team's 8:1 bit-select mux.
- Accepts an 8-bit word over a valid/ready handshake and holds it.
- Steps the 3-bit select through all positions with a counter, emitting one bit per accepted downstream beat.
- Used as the TX front end for bit-serial datapaths in the lab designs.

Parameters:
- MSB_FIRST, 0, 0 = emit d[0] first (select counts 0→7); 1 = emit d[7] first (select counts 7→0).
- GAP_CYCLES, 0, number of idle cycles inserted after each word before in_ready reasserts (0–15).

Ports:
- clk  input  1  single clock, all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on rising clk.
- in_data  input  8  parallel word to serialise.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word.
- ser_bit  output  1  current serial bit (output of the internal 8:1 select).
- ser_valid  output  1  ser_bit is valid.
- ser_ready  input  1  downstream accepts ser_bit this cycle.
- ser_last  output  1  final bit of the current word.
- sel  output  3  current select index; debug/observation only.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Decided: one clock; reset is synchronous and active-low. Port names are clk and rst_n.
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, hold register=0, select counter=0, gap counter=0.
  - Outputs: ser_valid=0, ser_last=0, ser_bit=0, busy=0, sel=0.
  - in_ready is forced 0 while rst_n=0.
  - Reset mid-word aborts the word; no further bits are emitted.
- States:
  - IDLE: in_ready=1, ser_valid=0, ser_bit gated to 0. When in_valid & in_ready, capture in_data into hold; load counter with 0 (MSB_FIRST=0) or 7 (MSB_FIRST=1); go to SEND.
  - SEND: in_ready=0, ser_valid=1, ser_bit = hold[sel].
    - Handshake completes only when ser_valid & ser_ready.
    - Without ser_ready: hold all state; ser_bit and sel stay stable.
    - On a completed beat, not the last index: counter +1 (or −1 for MSB_FIRST).
    - On a completed beat at the last index (7, or 0 for MSB_FIRST): go to PARITY if the feature is enabled; else GAP if GAP_CYCLES>0; else IDLE.
  - GAP: ser_valid=0; count GAP_CYCLES cycles, then go to IDLE.
- ser_last = ser_valid & final data bit. With parity enabled, ser_last is asserted on the parity bit instead.
- Latency:
  - Word accepted at edge N gives first bit valid in cycle N+1.
  - Throughput with no stalls and GAP_CYCLES=0: 8 beats per word plus 1 IDLE cycle.
  - in_ready is never asserted in SEND, so no overlap between words.
- Counter arithmetic is 3-bit unsigned. The counter never wraps inside a word; the last index always forces the state change.
- in_valid held high across words: the next word is accepted on the first IDLE cycle.
- ser_ready toggling: exactly one bit is consumed per high cycle while in SEND.

Optional Feature:
- Macro: MUX8_SERIALIZER_PARITY_EN.
- Defined:
  - An extra PARITY state follows the 8th data bit.
  - ser_bit = even parity of hold (XOR of all 8 bits); ser_valid=1; ser_last=1.
  - Advances on ser_ready, then goes to GAP or IDLE.
  - 9 beats per word.
- Undefined: the PARITY state and parity logic are absent; 8 beats per word; ser_last is on data bit 8.

Decomposition:
- Shared package mux8_ser_pkg:
  - state enum: IDLE, SEND, PARITY, GAP (2-bit encoding).
  - SEL_W=3 and DATA_W=8 constants.
  - first/last index localparams derived from MSB_FIRST.
- Sub-module: instantiate the team's existing mux8to1 as the bit selector. Connect hold to d, the counter to s, and o to ser_bit before the IDLE gating. The block must not re-implement the select logic.

Test Plan:
- Reset then in_data=8'hA5, MSB_FIRST=0, ser_ready=1 → bits 1,0,1,0,0,1,0,1 in cycles N+1..N+8; ser_last only on cycle N+8; in_ready back high at N+9.
- MSB_FIRST=1, in_data=8'h81, ser_ready=1 → sel sequence 7..0, bits 1,0,0,0,0,0,0,1.
- in_data=8'h3C with ser_ready low for 3 cycles at bit 2 → sel=2 and ser_bit=1 held stable for all stall cycles; total 8 accepted beats, no bit lost or duplicated.
- Reset asserted after 4th bit of 8'hFF → next edge: ser_valid=0, busy=0, sel=0. After release, 8'h0F is sent cleanly starting from sel=0.
- GAP_CYCLES=3, two back-to-back words 8'h01, 8'h02 with in_valid held → exactly 3 idle cycles plus 1 IDLE cycle between ser_last of word 1 and first bit of word 2.
- With MUX8_SERIALIZER_PARITY_EN: 8'h07 → 8 data bits then parity bit=1 with ser_last=1; 8'h03 → parity bit=0.
